// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter
//   Shares one seven-segment display driver between NUM_CLIENTS requesters.
//   Ownership is granted round-robin. An owner keeps the display until it
//   drops its request, or until it has held it for HOLD_CYCLES cycles while
//   another client is waiting. The owner's frame, digit mask and
//   decimal-point mask are forwarded to the driver through one register
//   stage. The outputs are blank while nobody owns the display.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   req                   : per-client level request
//   client_data           : packed frames, client k at [k*WIDTH_NIBBLES*4 +: WIDTH_NIBBLES*4]
//   client_digit_enable   : packed digit masks, client k at [k*WIDTH_NIBBLES +: WIDTH_NIBBLES]
//   client_dp_enable      : packed decimal-point masks, same packing
//   grant                 : one-hot (or zero) current owner
//   busy                  : grant is nonzero
//   data / digit_enable / decimal_point_enable : registered owner slice to driver
//   dbg_state, dbg_rr_ptr, dbg_hold_cnt        : arbiter state for observation
//
// Handshake: req is a level. A client holds it for as long as it wants the
// display. grant[k] high means client k's slice reaches the driver outputs
// one cycle later. There is no other acknowledge.
module seg7_display_arbiter #(
   parameter int NUM_CLIENTS   = 4,
   parameter int WIDTH_NIBBLES = 6,
   parameter int HOLD_CYCLES   = 1024
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_CLIENTS-1:0]                 req,
   input  logic [NUM_CLIENTS*WIDTH_NIBBLES*4-1:0] client_data,
   input  logic [NUM_CLIENTS*WIDTH_NIBBLES-1:0]   client_digit_enable,
   input  logic [NUM_CLIENTS*WIDTH_NIBBLES-1:0]   client_dp_enable,
   output logic [NUM_CLIENTS-1:0]                 grant,
   output logic                                   busy,
   output logic [WIDTH_NIBBLES*4-1:0]             data,
   output logic [WIDTH_NIBBLES-1:0]               digit_enable,
   output logic [WIDTH_NIBBLES-1:0]               decimal_point_enable,
   output logic                                   dbg_state,
   output logic [$clog2(NUM_CLIENTS)-1:0]         dbg_rr_ptr,
   output logic [$clog2(HOLD_CYCLES+1)-1:0]       dbg_hold_cnt
);

   localparam int PTR_W  = $clog2(NUM_CLIENTS);
   localparam int HOLD_W = $clog2(HOLD_CYCLES+1);
   localparam int DW     = WIDTH_NIBBLES*4;

   typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

   state_t                   r_state, w_state_nxt;
   logic [NUM_CLIENTS-1:0]   r_grant, w_grant_nxt;
   logic [PTR_W-1:0]         r_rr_ptr, w_rr_nxt;
   logic [HOLD_W-1:0]        r_hold_cnt, w_hold_nxt;
   logic [DW-1:0]            r_data, w_data;
   logic [WIDTH_NIBBLES-1:0] r_dig, w_dig;
   logic [WIDTH_NIBBLES-1:0] r_dp, w_dp;

   logic [PTR_W:0]           w_pick_all;   // {found, index} over all requesters
   logic [PTR_W:0]           w_pick_oth;   // {found, index} excluding the owner
   logic                     w_owner_req;
   logic                     w_hold_full;

   // Round-robin scan starting at ptr. The mask is doubled and rotated so
   // that offset i is bit i. Iterating downward lets the smallest offset
   // win, because its assignment comes last.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] mask,
                                              input logic [PTR_W-1:0]       ptr);
      logic [2*NUM_CLIENTS-1:0] rot;
      logic [PTR_W:0]           res;
      int                       t;
      rot = {mask, mask} >> ptr;
      res = '0;
      for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
         if (rot[i]) begin
            t = int'(ptr) + i;
            if (t >= NUM_CLIENTS) t = t - NUM_CLIENTS;
            res = {1'b1, PTR_W'(t)};
         end
      end
      return res;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
      return (idx == PTR_W'(NUM_CLIENTS-1)) ? '0 : idx + PTR_W'(1);
   endfunction

   assign w_pick_all  = rr_pick(req, r_rr_ptr);
   assign w_pick_oth  = rr_pick(req & ~r_grant, r_rr_ptr);
   assign w_owner_req = |(req & r_grant);
   assign w_hold_full = (r_hold_cnt == HOLD_W'(HOLD_CYCLES));

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_rr_nxt    = r_rr_ptr;
      w_hold_nxt  = r_hold_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_pick_all[PTR_W]) begin
               w_state_nxt = S_OWNED;
               w_grant_nxt = NUM_CLIENTS'(1) << w_pick_all[PTR_W-1:0];
               w_rr_nxt    = next_ptr(w_pick_all[PTR_W-1:0]);
               w_hold_nxt  = '0;
            end
         end
         S_OWNED: begin
            // Both a released request and an expired hold hand the display
            // to the next waiting client. Only a release can empty it.
            if (!w_owner_req || w_hold_full) begin
               if (w_pick_oth[PTR_W]) begin
                  w_grant_nxt = NUM_CLIENTS'(1) << w_pick_oth[PTR_W-1:0];
                  w_rr_nxt    = next_ptr(w_pick_oth[PTR_W-1:0]);
                  w_hold_nxt  = '0;
               end else if (!w_owner_req) begin
                  w_state_nxt = S_IDLE;
                  w_grant_nxt = '0;
                  w_hold_nxt  = '0;
               end
            end else begin
               w_hold_nxt = r_hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   // Owner slice mux. r_grant is one-hot or zero, so OR-ing is a clean
   // select, and a zero grant yields a blank frame.
   always_comb begin
      w_data = '0;
      w_dig  = '0;
      w_dp   = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (r_grant[k]) begin
            w_data = w_data | client_data[k*DW +: DW];
            w_dig  = w_dig  | client_digit_enable[k*WIDTH_NIBBLES +: WIDTH_NIBBLES];
            w_dp   = w_dp   | client_dp_enable[k*WIDTH_NIBBLES +: WIDTH_NIBBLES];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
         r_data     <= '0;
         r_dig      <= '0;
         r_dp       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_data     <= w_data;
         r_dig      <= w_dig;
         r_dp       <= w_dp;
      end
   end

   assign grant                = r_grant;
   assign busy                 = |r_grant;
   assign data                 = r_data;
   assign digit_enable         = r_dig;
   assign decimal_point_enable = r_dp;
   assign dbg_state            = r_state;
   assign dbg_rr_ptr           = r_rr_ptr;
   assign dbg_hold_cnt         = r_hold_cnt;

endmodule

// File: doc/seg7_display_arbiter.md
SEG7_DISPLAY_ARBITER -- requirements
Module: seg7_display_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter WIDTH_NIBBLES, default 6: digits per client frame, equal to the display driver's WIDTH_NIBBLES.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1024: minimum ownership time before preemption, legal range >=1.
REQ-004 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, NUM_CLIENTS: per-client display request; level, held while the client wants the display.
REQ-007 SHALL have port client_data, input, NUM_CLIENTS*WIDTH_NIBBLES*4: packed hex frames; client k occupies slice [k*WIDTH_NIBBLES*4 +: WIDTH_NIBBLES*4].
REQ-008 SHALL have port client_digit_enable, input, NUM_CLIENTS*WIDTH_NIBBLES: packed digit masks, client k at [k*WIDTH_NIBBLES +: WIDTH_NIBBLES].
REQ-009 SHALL have port client_dp_enable, input, NUM_CLIENTS*WIDTH_NIBBLES: packed decimal-point masks, packed as in REQ-008.
REQ-010 SHALL have port grant, output, NUM_CLIENTS: one-hot or zero; the current display owner.
REQ-011 SHALL have port busy, output, 1: high when grant is nonzero.
REQ-012 SHALL have port data, output, WIDTH_NIBBLES*4: frame for the display driver's data input.
REQ-013 SHALL have port digit_enable, output, WIDTH_NIBBLES: mask for the driver's digit_enable input.
REQ-014 SHALL have port decimal_point_enable, output, WIDTH_NIBBLES: mask for the driver's decimal_point_enable input.

Function
REQ-015 SHALL implement two states: IDLE (grant zero) and OWNED (exactly one grant bit set).
REQ-016 SHALL keep a round-robin pointer rr_ptr, width clog2(NUM_CLIENTS), and select winners as the first set req bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_CLIENTS.
REQ-017 SHALL, in IDLE with req nonzero, assert the winner's grant on the next cycle, enter OWNED and clear hold_cnt to 0.
REQ-018 SHALL, in IDLE with req zero, remain in IDLE.
REQ-019 SHALL, in OWNED, increment hold_cnt every cycle and saturate it at HOLD_CYCLES.
REQ-020 SHALL, in OWNED when req[owner] is 0, hand off on the next cycle: to the round-robin winner among the other requesters, or to IDLE if none request; there is no idle gap on a handoff.
REQ-021 SHALL, in OWNED when hold_cnt==HOLD_CYCLES and (req & ~grant) is nonzero, preempt: the next cycle grants the round-robin winner among the other requesters.
REQ-022 SHALL, in OWNED when hold_cnt==HOLD_CYCLES but no other client requests, keep the owner with hold_cnt held at HOLD_CYCLES.
REQ-023 SHALL, on every grant change to a new owner, set rr_ptr to new_owner+1 modulo NUM_CLIENTS and clear hold_cnt to 0.
REQ-024 SHALL compute the round-robin winner from req and rr_ptr in the same cycle; when several clients request simultaneously, only the REQ-016 scan order decides.
REQ-025 SHALL register data, digit_enable and decimal_point_enable each cycle from the slice selected by the registered grant, giving exactly one cycle of latency from grant to outputs.
REQ-026 SHALL, while grant is zero, register data=0, digit_enable=0 and decimal_point_enable=0, so the display is blanked.
REQ-027 SHALL track live changes to the owner's slice with one-cycle latency; no frame latching.
REQ-028 SHALL never assert more than one grant bit in any cycle.

Reset
REQ-029 SHALL, while reset is high at a clock edge, force grant=0, busy=0, data=0, digit_enable=0, decimal_point_enable=0, rr_ptr=0, hold_cnt=0 and state IDLE, regardless of req.
REQ-030 SHALL treat reset asserted mid-ownership the same way: the grant drops on that edge and arbitration restarts from rr_ptr=0 on the first cycle after reset is released.

Verification
REQ-031 SHALL pass this scenario (NUM_CLIENTS=4, HOLD_CYCLES=8): req=0010 after reset -> grant=0010 one cycle later, then data equals client 1's slice one cycle after that.
REQ-032 SHALL pass this scenario: req=1111 from IDLE with rr_ptr=0 -> grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 9 cycles (hold_cnt 0..8, then switch).
REQ-033 SHALL pass this scenario: owner 0 drops req at hold_cnt=3 while req[2]=1 -> grant=0100 on the next cycle, with no zero-grant cycle.
REQ-034 SHALL pass this scenario: single requester 3 held for 50 cycles -> grant stays 1000 and hold_cnt saturates at 8.
REQ-035 SHALL pass this scenario: all req drop -> grant=0 on the next cycle, then digit_enable=0 and data=0 the cycle after.
REQ-036 SHALL pass this scenario: reset pulsed for 1 cycle while client 2 owns with req=1111 -> grant=0 on that edge, then grant=0001 on the first cycle after reset.
